// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, state enum and start-position helper for the chick-race tracker
//
// Purpose: single source of truth for track size, player count, index widths
// and the tracker FSM encoding. Imported by occupancy_check and player_tracker.
// Ports: none (package).
package game_pkg;

    localparam int NUM_TILES     = 16;
    localparam int MAX_PLAYERS   = 4;
    localparam int START_SPACING = 4;
    localparam int TILE_W        = $clog2(NUM_TILES);
    localparam int PLAYER_W      = $clog2(MAX_PLAYERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        WAIT = 2'd2,
        MOVE = 2'd3
    } tracker_state_t;

    // Game-start tile of player idx. The multiply wraps naturally at TILE_W bits.
    function automatic logic [TILE_W-1:0] start_pos(input int idx);
        return TILE_W'(idx * START_SPACING);
    endfunction

endpackage

// File: rtl/occupancy_check.sv
// rtl/occupancy_check.sv - combinational test of one candidate tile against all active opponents
//
// Purpose: reports whether any active opponent (index <= N, index != T) sits on
// the candidate tile, and which ones.
// Ports:
//   cand          in   tile under test
//   positions     in   packed player positions, player i in [TILE_W*i +: TILE_W]
//   N             in   active players minus one
//   T             in   current player (excluded from the comparison)
//   occupied      out  1 = at least one active opponent on cand
//   occupant_mask out  bit j = opponent j on cand
module occupancy_check
    import game_pkg::*;
(
    input  logic [TILE_W-1:0]             cand,
    input  logic [MAX_PLAYERS*TILE_W-1:0] positions,
    input  logic [PLAYER_W-1:0]           N,
    input  logic [PLAYER_W-1:0]           T,
    output logic                          occupied,
    output logic [MAX_PLAYERS-1:0]        occupant_mask
);

    always_comb begin
        occupant_mask = '0;
        for (int j = 0; j < MAX_PLAYERS; j++) begin
            if ((PLAYER_W'(j) <= N) && (PLAYER_W'(j) != T) &&
                (positions[j*TILE_W +: TILE_W] == cand)) begin
                occupant_mask[j] = 1'b1;
            end
        end
    end

    assign occupied = |occupant_mask;

endmodule

// File: rtl/player_tracker.sv
// rtl/player_tracker.sv - chick position registers, next-free-tile search and move commit
//
// Purpose: holds every player's tile, searches one candidate per cycle for the
// first tile ahead of player T that no active opponent occupies, presents it on
// position_data, then commits or abandons the move when the match result returns.
// Optional feature macro: STEAL_TAIL_EN (reports jumped opponents on steal_*).
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start          new game: reinitialise positions (highest priority)
//   N, T           active players minus one; current player
//   turn_start     begin target search for player T (IDLE only)
//   move_req, go   match result present / 1 = matched, move (WAIT only)
//   position_data  tile the current player must reveal
//   target_valid   high in WAIT
//   busy           high in SEEK and MOVE
//   move_done      one-cycle pulse in MOVE; moved = player advanced
//   positions      packed positions, player i in bits [4i+3:4i]
//   turn_err       one-cycle pulse after turn_start with T > N
//   steal_valid    one-cycle pulse with move_done when opponents were jumped
//   steal_mask     bit i = opponent i was jumped
module player_tracker
    import game_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PLAYER_W-1:0]           N,
    input  logic [PLAYER_W-1:0]           T,
    input  logic                          turn_start,
    input  logic                          move_req,
    input  logic                          go,
    output logic [TILE_W-1:0]             position_data,
    output logic                          target_valid,
    output logic                          busy,
    output logic                          move_done,
    output logic                          moved,
    output logic [MAX_PLAYERS*TILE_W-1:0] positions,
    output logic                          turn_err,
    output logic                          steal_valid,
    output logic [MAX_PLAYERS-1:0]        steal_mask
);

    tracker_state_t        state;
    tracker_state_t        state_next;
    logic [TILE_W-1:0]     pos [MAX_PLAYERS];
    logic [TILE_W-1:0]     cand;
    logic [TILE_W-1:0]     target;
    logic [PLAYER_W-1:0]   t_r;
    logic                  go_r;
    logic                  turn_err_r;
    logic                  occupied;
    logic [MAX_PLAYERS-1:0] occ_mask;

    // Only a legal turn leaves IDLE; an illegal one just raises turn_err.
    logic turn_ok;
    assign turn_ok = turn_start && (T <= N);

    always_comb begin
        positions = '0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            positions[i*TILE_W +: TILE_W] = pos[i];
        end
    end

    // T is compared through the latched copy so a mid-search change on T is harmless.
    occupancy_check u_occupancy_check (
        .cand          (cand),
        .positions     (positions),
        .N             (N),
        .T             (t_r),
        .occupied      (occupied),
        .occupant_mask (occ_mask)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (turn_ok) state_next = SEEK;
            SEEK: if (!occupied) state_next = WAIT;
            WAIT: if (move_req) state_next = MOVE;
            MOVE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= '0;
            target     <= '0;
            t_r        <= '0;
            go_r       <= 1'b0;
            turn_err_r <= 1'b0;
            for (int i = 0; i < MAX_PLAYERS; i++) pos[i] <= start_pos(i);
        end else if (start) begin
            state      <= IDLE;
            cand       <= '0;
            target     <= '0;
            t_r        <= '0;
            go_r       <= 1'b0;
            turn_err_r <= 1'b0;
            for (int i = 0; i < MAX_PLAYERS; i++) pos[i] <= start_pos(i);
        end else begin
            state      <= state_next;
            turn_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (turn_ok) begin
                        t_r  <= T;
                        cand <= pos[T] + TILE_W'(1);
                    end else if (turn_start) begin
                        turn_err_r <= 1'b1;
                    end
                end
                SEEK: begin
                    // Wrap 15 -> 0 comes for free from the TILE_W-bit add.
                    if (occupied) cand   <= cand + TILE_W'(1);
                    else          target <= cand;
                end
                WAIT: begin
                    if (move_req) begin
                        go_r <= go;
                        if (go) pos[t_r] <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    assign position_data = target;
    assign target_valid  = (state == WAIT);
    assign busy          = (state == SEEK) || (state == MOVE);
    assign move_done     = (state == MOVE);
    assign moved         = (state == MOVE) && go_r;
    assign turn_err      = turn_err_r;

`ifdef STEAL_TAIL_EN
    // Accumulates every opponent hopped over during the current search.
    logic [MAX_PLAYERS-1:0] skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip <= '0;
        end else if (start) begin
            skip <= '0;
        end else if (state == IDLE && turn_ok) begin
            skip <= '0;
        end else if (state == SEEK && occupied) begin
            skip <= skip | occ_mask;
        end
    end

    assign steal_valid = (state == MOVE) && go_r && (|skip);
    assign steal_mask  = steal_valid ? skip : '0;
`else
    logic unused_occ_mask;
    assign unused_occ_mask = ^occ_mask;
    assign steal_valid     = 1'b0;
    assign steal_mask      = '0;
`endif

endmodule

// File: tb/tb_player_tracker.sv
// tb/tb_player_tracker.sv - randomized self-checking bench for player_tracker
module tb_player_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  N = 2'd0;
    logic [1:0]  T = 2'd0;
    logic        turn_start = 1'b0;
    logic        move_req = 1'b0;
    logic        go = 1'b0;
    logic [3:0]  position_data;
    logic        target_valid;
    logic        busy;
    logic        move_done;
    logic        moved;
    logic [15:0] positions;
    logic        turn_err;
    logic        steal_valid;
    logic [3:0]  steal_mask;

    int vectors = 0;
    int miscompares = 0;
    int mpos [4];

    player_tracker dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .N             (N),
        .T             (T),
        .turn_start    (turn_start),
        .move_req      (move_req),
        .go            (go),
        .position_data (position_data),
        .target_valid  (target_valid),
        .busy          (busy),
        .move_done     (move_done),
        .moved         (moved),
        .positions     (positions),
        .turn_err      (turn_err),
        .steal_valid   (steal_valid),
        .steal_mask    (steal_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mpos[i] = (i * 4) % 16;
    endtask

    function automatic logic [31:0] model_positions();
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++) r = r | ((mpos[i] % 16) << (4 * i));
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tv"}, target_valid, 0);
        check({tag, "_done"}, move_done, 0);
        check({tag, "_moved"}, moved, 0);
        check({tag, "_terr"}, turn_err, 0);
        check({tag, "_sv"}, steal_valid, 0);
        check({tag, "_sm"}, steal_mask, 0);
        check({tag, "_pos"}, positions, model_positions());
    endtask

    // One full turn against the model. abort = pulse start while waiting in WAIT.
    task automatic do_turn(input int n, input int t, input bit abort, input bit go_v, input int wait_extra);
        int cand;
        int k;
        int mask;
        bit hit;
        bit exp_sv;
        int exp_sm;
        N = 2'(n);
        T = 2'(t);
        turn_start = 1'b1;
        tick();
        turn_start = 1'b0;
        if (t > n) begin
            check("err_pulse", turn_err, 1);
            check("err_busy", busy, 0);
            check("err_tv", target_valid, 0);
            tick();
            check_quiet("err_after");
            return;
        end
        // Reference: walk forward from the player's tile until no active opponent sits there.
        cand = (mpos[t] + 1) % 16;
        k = 0;
        mask = 0;
        for (int guard = 0; guard < 16; guard++) begin
            hit = 0;
            for (int j = 0; j <= n; j++) begin
                if (j != t && mpos[j] == cand) begin
                    hit = 1;
                    mask = mask | (1 << j);
                end
            end
            if (!hit) break;
            cand = (cand + 1) % 16;
            k++;
        end
        for (int c = 0; c < k + 1; c++) begin
            check("seek_busy", busy, 1);
            check("seek_tv", target_valid, 0);
            T = 2'($urandom_range(0, 3));
            tick();
        end
        check("wait_tv", target_valid, 1);
        check("wait_data", position_data, cand);
        check("wait_busy", busy, 0);
        for (int w = 0; w < wait_extra; w++) begin
            turn_start = 1'b1;
            T = 2'($urandom_range(0, 3));
            tick();
            turn_start = 1'b0;
            check("wait_hold_tv", target_valid, 1);
            check("wait_hold_data", position_data, cand);
        end
        if (abort) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            model_reset();
            check_quiet("abort");
            return;
        end
        move_req = 1'b1;
        go = go_v;
        tick();
        move_req = 1'b0;
        go = 1'($urandom_range(0, 1));
        if (go_v) mpos[t] = cand;
`ifdef STEAL_TAIL_EN
        exp_sv = go_v && (mask != 0);
`else
        exp_sv = 1'b0;
`endif
        exp_sm = exp_sv ? mask : 0;
        check("move_done", move_done, 1);
        check("move_moved", moved, go_v);
        check("move_tv", target_valid, 0);
        check("move_busy", busy, 1);
        check("move_pos", positions, model_positions());
        check("move_sv", steal_valid, exp_sv);
        check("move_sm", steal_mask, exp_sm);
        tick();
        check_quiet("after_move");
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        check_quiet("reset");
        rst = 1'b0;
        N = 2'd3;
        tick();
        check("reset_pos", positions, 32'hC840);

        // Free tile directly ahead.
        do_turn(3, 0, 1'b0, 1'b1, 0);
        check("first_target_pos0", positions[3:0], 1);

        // move_req outside WAIT is ignored.
        move_req = 1'b1;
        go = 1'b1;
        tick();
        move_req = 1'b0;
        check_quiet("stray_move_req");

        // Illegal player index.
        do_turn(1, 3, 1'b0, 1'b0, 0);

        for (int i = 0; i < 400; i++) begin
            do_turn($urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a search.
        N = 2'd3;
        T = 2'd1;
        turn_start = 1'b1;
        tick();
        turn_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_quiet("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check_quiet("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
